// File: rtl/result_reporter_pkg.sv
// Shared definitions for the result-report framer: FSM states, frame
// constants and the payload byte order.
package result_reporter_pkg;

    // Frame sequencing states; IDLE must stay encoded as 0.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_TYPE     = 3'd2,
        ST_LENGTH   = 3'd3,
        ST_PAYLOAD  = 3'd4,
        ST_CHECKSUM = 3'd5
    } state_e;

    // Payload length in bytes and whole frame length:
    // sync + type + length + payload + checksum.
    localparam int unsigned LEN         = 19;
    localparam int unsigned FRAME_BYTES = LEN + 4;
    localparam int unsigned SNAP_W      = LEN * 8;

    localparam logic [7:0] LEN_BYTE = 8'h13;
    localparam logic [4:0] LAST_IDX = 5'(LEN - 1);

    // Payload byte order, MSB first:
    //   bytes  0..1  error_count
    //   bytes  2..5  min_latency
    //   bytes  6..9  max_latency
    //   bytes 10..13 average_latency
    //   bytes 14..17 throughput
    //   byte  18     {6'b0, test_mode}
    // Byte 0 sits in the top 8 bits of the snapshot.
    function automatic logic [SNAP_W-1:0] pack_payload(
        input logic [15:0] error_count,
        input logic [31:0] min_latency,
        input logic [31:0] max_latency,
        input logic [31:0] average_latency,
        input logic [31:0] throughput,
        input logic [1:0]  test_mode
    );
        return {error_count, min_latency, max_latency, average_latency,
                throughput, 6'b000000, test_mode};
    endfunction

    // Select payload byte idx (0 = first transmitted) from the snapshot.
    function automatic logic [7:0] payload_byte(
        input logic [SNAP_W-1:0] snap,
        input logic [4:0]        idx
    );
        logic [SNAP_W-1:0] shifted;
        shifted = snap << {idx, 3'b000};
        return shifted[SNAP_W-1 -: 8];
    endfunction

    // XOR of all payload bytes; the checksum folds in TYPE and LEN on top.
    function automatic logic [7:0] payload_xor(
        input logic [SNAP_W-1:0] snap
    );
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < int'(LEN); i++) begin
            acc = acc ^ snap[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/result_reporter.sv
// Result-report framer: snapshots the test statistics on report_start and
// streams a 23-byte frame (sync, type, length, payload, checksum) over a
// valid/ready byte link.
//
// Handshake: a byte transfers on a rising edge where tx_valid && tx_ready.
// Once tx_valid rises it stays high, with tx_data unchanged, until that
// transfer happens; tx_valid never depends on tx_ready.
module result_reporter
    import result_reporter_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] TYPE_BYTE = 8'h52
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        report_start,
    input  logic [15:0] error_count,
    input  logic [31:0] min_latency,
    input  logic [31:0] max_latency,
    input  logic [31:0] average_latency,
    input  logic [31:0] throughput,
    input  logic [1:0]  test_mode,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        report_done,
    output logic        report_dropped,
    output logic [2:0]  state_dbg
);

    state_e            state_q;
    state_e            state_d;
    logic [4:0]        idx_q;
    logic [SNAP_W-1:0] snap_q;
    logic              done_q;
    logic              dropped_q;
    logic [7:0]        csum;
    logic              start_accept;
    logic              handshake;

    // A start is taken only while no frame is in progress.
    assign start_accept = report_start && (state_q == ST_IDLE);
    assign handshake    = tx_valid && tx_ready;

    // The checksum depends only on the snapshot, so it is derived from it
    // directly rather than accumulated byte by byte.
    assign csum = TYPE_BYTE ^ LEN_BYTE ^ payload_xor(snap_q);

    assign busy           = (state_q != ST_IDLE);
    assign report_done    = done_q;
    assign report_dropped = dropped_q;
    assign state_dbg      = state_q;

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and byte-stream outputs; each state advances on a handshake.
    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) begin
                    state_d = ST_TYPE;
                end
            end
            ST_TYPE: begin
                tx_valid = 1'b1;
                tx_data  = TYPE_BYTE;
                if (tx_ready) begin
                    state_d = ST_LENGTH;
                end
            end
            ST_LENGTH: begin
                tx_valid = 1'b1;
                tx_data  = LEN_BYTE;
                if (tx_ready) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                tx_valid = 1'b1;
                tx_data  = payload_byte(snap_q, idx_q);
                if (tx_ready && (idx_q == LAST_IDX)) begin
                    state_d = ST_CHECKSUM;
                end
            end
            ST_CHECKSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Payload index walks 0..18 and rewinds after the last payload byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 5'd0;
        end else if ((state_q == ST_PAYLOAD) && handshake) begin
            if (idx_q == LAST_IDX) begin
                idx_q <= 5'd0;
            end else begin
                idx_q <= idx_q + 5'd1;
            end
        end
    end

    // Snapshot captured only on an accepted start; later input changes and
    // ignored starts leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q <= '0;
        end else if (start_accept) begin
            snap_q <= pack_payload(error_count, min_latency, max_latency,
                                   average_latency, throughput, test_mode);
        end
    end

    // report_done pulses for the cycle after the checksum transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == ST_CHECKSUM) && tx_ready;
        end
    end

    // Sticky flag for starts that arrive while busy; an accepted start clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped_q <= 1'b0;
        end else if (start_accept) begin
            dropped_q <= 1'b0;
        end else if (report_start && busy) begin
            dropped_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_reporter.sv
// Directed testbench for result_reporter: hand-computed frame bytes plus a
// small frame model feeding an expected-byte queue.
module tb_result_reporter;

    logic        clk;
    logic        rst;
    logic        report_start;
    logic [15:0] error_count;
    logic [31:0] min_latency;
    logic [31:0] max_latency;
    logic [31:0] average_latency;
    logic [31:0] throughput;
    logic [1:0]  test_mode;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        report_done;
    logic        report_dropped;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    result_reporter dut (
        .clk            (clk),
        .rst            (rst),
        .report_start   (report_start),
        .error_count    (error_count),
        .min_latency    (min_latency),
        .max_latency    (max_latency),
        .average_latency(average_latency),
        .throughput     (throughput),
        .test_mode      (test_mode),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .report_done    (report_done),
        .report_dropped (report_dropped),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected frame from the current input values.
    task automatic build_expected();
        logic [7:0] pl[19];
        logic [7:0] cs;
        pl[0]  = error_count[15:8];      pl[1]  = error_count[7:0];
        pl[2]  = min_latency[31:24];     pl[3]  = min_latency[23:16];
        pl[4]  = min_latency[15:8];      pl[5]  = min_latency[7:0];
        pl[6]  = max_latency[31:24];     pl[7]  = max_latency[23:16];
        pl[8]  = max_latency[15:8];      pl[9]  = max_latency[7:0];
        pl[10] = average_latency[31:24]; pl[11] = average_latency[23:16];
        pl[12] = average_latency[15:8];  pl[13] = average_latency[7:0];
        pl[14] = throughput[31:24];      pl[15] = throughput[23:16];
        pl[16] = throughput[15:8];       pl[17] = throughput[7:0];
        pl[18] = {6'b000000, test_mode};
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h13);
        cs = 8'h52 ^ 8'h13;
        for (int i = 0; i < 19; i++) begin
            exp_q.push_back(pl[i]);
            cs = cs ^ pl[i];
        end
        exp_q.push_back(cs);
    endtask

    // Compare the captured frame against the expected queue.
    task automatic score_frame(input string tag);
        check({tag, "_len"}, rx_q.size(), 23);
        for (int i = 0; i < 23; i++) begin
            if (i < rx_q.size() && exp_q.size() > 0) begin
                check($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q.pop_front());
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_inputs(input logic [15:0] e, input logic [31:0] mn, input logic [31:0] mx,
                              input logic [31:0] av, input logic [31:0] tp, input logic [1:0] m);
        error_count = e; min_latency = mn; max_latency = mx;
        average_latency = av; throughput = tp; test_mode = m;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_report();
        report_start = 1'b1;
        @(negedge clk);
        report_start = 1'b0;
    endtask

    // Starting in the first cycle after acceptance, receive bytes until
    // report_done. done_cyc counts cycles from that first cycle.
    task automatic collect_frame(input bit toggle, input int drop_at, input bit scramble,
                                 output int done_cyc, output int first_valid);
        bit         stall;
        bit         drop_sent;
        logic [7:0] prev;
        stall = 0; drop_sent = 0; prev = 8'h00;
        done_cyc = -1; first_valid = -1;
        rx_q.delete();
        for (int c = 0; c < 200; c++) begin
            if (report_done) begin
                done_cyc = c;
                break;
            end
            tx_ready = toggle ? ((c % 2) == 0) : 1'b1;
            if (drop_at >= 0 && rx_q.size() == drop_at && !drop_sent) begin
                report_start = 1'b1;
                drop_sent = 1;
            end else begin
                report_start = 1'b0;
            end
            if (scramble) begin
                set_inputs(16'($urandom), $urandom, $urandom, $urandom, $urandom,
                           2'($urandom_range(0, 3)));
            end
            if (tx_valid && first_valid < 0) first_valid = c;
            if (first_valid >= 0) begin
                check("valid_hold", tx_valid, 1);
                check("busy_hold", busy, 1);
            end
            if (stall) check("stall_stable", tx_data, prev);
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            stall = tx_valid && !tx_ready;
            prev  = tx_data;
            @(negedge clk);
        end
        report_start = 1'b0;
        tx_ready = 1'b1;
        if (done_cyc < 0) check("frame_timeout", 0, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, state_dbg, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, tx_valid, 0);
        check({tag, "_data"}, tx_data, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int done_cyc;
        int first_valid;
        logic [7:0] saved_b10;

        rst = 1'b1; report_start = 1'b0; tx_ready = 1'b1;
        set_inputs(16'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_done", report_done, 0);
        check("reset_dropped", report_dropped, 0);
        rst = 1'b0;
        @(negedge clk);

        // All zeros, ready always high: checksum 52^13 = 41.
        build_expected();
        start_report();
        check("zero_first", tx_data, 8'hA5);
        collect_frame(0, -1, 0, done_cyc, first_valid);
        check("zero_csum", (rx_q.size() == 23) ? rx_q[22] : 8'hxx, 8'h41);
        check("zero_done_cycle", done_cyc + 1, 24);
        score_frame("zero");
        check("zero_done", report_done, 1);
        check_idle("zero_after");
        @(negedge clk);
        check("zero_done_pulse", report_done, 0);

        // Error count 0102: payload starts 01,02; checksum 41^01^02 = 42.
        set_inputs(16'h0102, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
        build_expected();
        start_report();
        collect_frame(0, -1, 0, done_cyc, first_valid);
        check("err_p0", (rx_q.size() == 23) ? rx_q[3] : 8'hxx, 8'h01);
        check("err_p1", (rx_q.size() == 23) ? rx_q[4] : 8'hxx, 8'h02);
        check("err_csum", (rx_q.size() == 23) ? rx_q[22] : 8'hxx, 8'h42);
        score_frame("err");
        @(negedge clk);

        // DEADBEEF, mode 3, ready toggling: 45 cycles first valid to done.
        set_inputs(16'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 2'b11);
        build_expected();
        start_report();
        collect_frame(1, -1, 0, done_cyc, first_valid);
        check("stall_b5", (rx_q.size() == 23) ? rx_q[5] : 8'hxx, 8'hDE);
        check("stall_b6", (rx_q.size() == 23) ? rx_q[6] : 8'hxx, 8'hAD);
        check("stall_b7", (rx_q.size() == 23) ? rx_q[7] : 8'hxx, 8'hBE);
        check("stall_b8", (rx_q.size() == 23) ? rx_q[8] : 8'hxx, 8'hEF);
        check("stall_last_pl", (rx_q.size() == 23) ? rx_q[21] : 8'hxx, 8'h03);
        check("stall_csum", (rx_q.size() == 23) ? rx_q[22] : 8'hxx, 8'h60);
        check("stall_cycles", done_cyc - first_valid, 45);
        score_frame("stall");
        @(negedge clk);

        // Start at byte 10 is ignored; start in the done cycle is accepted.
        set_inputs(16'h1234, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 2'b01);
        build_expected();
        start_report();
        collect_frame(0, 10, 0, done_cyc, first_valid);
        score_frame("drop");
        check("drop_flag", report_dropped, 1);
        check("drop_done", report_done, 1);
        set_inputs(16'hCAFE, 32'h0, 32'h1, 32'h2, 32'h3, 2'b10);
        build_expected();
        start_report();
        check("b2b_first", tx_data, 8'hA5);
        check("b2b_valid", tx_valid, 1);
        check("b2b_dropped_clear", report_dropped, 0);
        collect_frame(0, -1, 0, done_cyc, first_valid);
        score_frame("b2b");
        @(negedge clk);

        // Start during the checksum handshake cycle is also ignored.
        build_expected();
        start_report();
        collect_frame(0, 22, 0, done_cyc, first_valid);
        score_frame("csum_drop");
        check("csum_drop_flag", report_dropped, 1);
        check("csum_drop_idle", busy, 0);
        @(negedge clk);
        check("csum_drop_nostart", tx_valid, 0);

        // Reset while payload byte 7 (frame byte 10) is on the link.
        set_inputs(16'hA1B2, 32'hC3D4E5F6, 32'h01020304, 32'h05060708, 32'h090A0B0C, 2'b01);
        build_expected();
        saved_b10 = exp_q[10];
        start_report();
        tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_byte", tx_data, saved_b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_mid");
        check("rst_mid_done", report_done, 0);
        check("rst_mid_dropped", report_dropped, 0);
        @(negedge clk);
        check("rst_mid_done2", report_done, 0);
        start_report();
        check("rst_restart", tx_data, 8'hA5);
        collect_frame(0, -1, 0, done_cyc, first_valid);
        score_frame("rst_restart");
        @(negedge clk);

        // Reset wins over a simultaneous start.
        rst = 1'b1; report_start = 1'b1;
        @(negedge clk);
        rst = 1'b0; report_start = 1'b0;
        @(negedge clk);
        check_idle("rst_prio");

        // Inputs scrambled every cycle after acceptance.
        set_inputs(16'h5A5A, 32'h0BADF00D, 32'hFEEDFACE, 32'h13579BDF, 32'h2468ACE0, 2'b10);
        build_expected();
        start_report();
        collect_frame(0, -1, 1, done_cyc, first_valid);
        score_frame("scramble");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
